// File: rtl/ctrl_fsm.sv
// Multi-cycle control unit: latches the fetched instruction, decodes it and paces
// the fetch/execute loop at four cycles per instruction until HALT.
module ctrl_fsm #(
  parameter logic [3:0]  HALT_OP = 4'hF,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instruction,
  output logic             en_pc,
  output logic [3:0]       rf_raddr_a,
  output logic [3:0]       rf_raddr_b,
  output logic [3:0]       rf_waddr,
  output logic             rf_we,
  output logic [3:0]       alu_op,
  output logic             alu_src_imm,
  output logic [7:0]       imm,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned IW   = 16;
  localparam int unsigned OP_W = 4;
  localparam int unsigned RA_W = 4;
  localparam int unsigned IM_W = 8;

  localparam logic [OP_W-1:0] OP_LDI = 4'h7;
  localparam logic [OP_W-1:0] OP_MAX = 4'h9;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     ir, ir_nxt;

  logic              en_pc_nxt;
  logic [RA_W-1:0]   rf_raddr_a_nxt;
  logic [RA_W-1:0]   rf_raddr_b_nxt;
  logic [RA_W-1:0]   rf_waddr_nxt;
  logic              rf_we_nxt;
  logic [OP_W-1:0]   alu_op_nxt;
  logic              alu_src_imm_nxt;
  logic [IM_W-1:0]   imm_nxt;
  logic              halted_nxt;
  logic              illegal_nxt;
  logic [CNT_W-1:0]  retired_nxt;

  // Decode source: the incoming word while IR is being loaded, IR afterwards.
  logic [IW-1:0]     dec_word;
  logic [OP_W-1:0]   dec_op;
  logic [OP_W-1:0]   ir_op;

  function automatic logic is_alu(input logic [OP_W-1:0] op);
    return (op >= 4'd1) && (op <= OP_MAX) && (op != HALT_OP);
  endfunction

  function automatic logic is_undef(input logic [OP_W-1:0] op);
    return (op > OP_MAX) && (op != HALT_OP);
  endfunction

  assign dec_word = (state == DECODE) ? instruction : ir;
  assign dec_op   = dec_word[15:12];
  assign ir_op    = ir[15:12];

  // Next-state and next-output logic.
  always_comb begin
    state_nxt       = state;
    ir_nxt          = ir;
    en_pc_nxt       = 1'b0;
    rf_raddr_a_nxt  = '0;
    rf_raddr_b_nxt  = '0;
    rf_waddr_nxt    = '0;
    rf_we_nxt       = 1'b0;
    alu_op_nxt      = '0;
    alu_src_imm_nxt = 1'b0;
    imm_nxt         = '0;
    halted_nxt      = halted;
    illegal_nxt     = illegal;
    retired_nxt     = retired;

    case (state)
      FETCH: begin
        state_nxt = DECODE;
      end

      DECODE, EXEC: begin
        rf_raddr_a_nxt  = dec_word[7:4];
        rf_raddr_b_nxt  = dec_word[3:0];
        rf_waddr_nxt    = dec_word[11:8];
        imm_nxt         = dec_word[7:0];
        alu_op_nxt      = is_alu(dec_op) ? dec_op : 4'h0;
        alu_src_imm_nxt = is_alu(dec_op) && (dec_op == OP_LDI);
        if (state == DECODE) begin
          ir_nxt    = instruction;
          state_nxt = EXEC;
        end else begin
          state_nxt = WB;
          rf_we_nxt = is_alu(ir_op);
          en_pc_nxt = (ir_op != HALT_OP);
        end
      end

      WB: begin
        if (ir_op == HALT_OP) begin
          state_nxt  = HALT;
          halted_nxt = 1'b1;
        end else begin
          state_nxt   = FETCH;
          retired_nxt = retired + CNT_W'(1);
          if (is_undef(ir_op)) begin
            illegal_nxt = 1'b1;
          end
        end
      end

      HALT: begin
        halted_nxt = 1'b1;
      end

      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  // State, IR and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= FETCH;
      ir          <= '0;
      en_pc       <= 1'b0;
      rf_raddr_a  <= '0;
      rf_raddr_b  <= '0;
      rf_waddr    <= '0;
      rf_we       <= 1'b0;
      alu_op      <= '0;
      alu_src_imm <= 1'b0;
      imm         <= '0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      retired     <= '0;
    end else begin
      state       <= state_nxt;
      ir          <= ir_nxt;
      en_pc       <= en_pc_nxt;
      rf_raddr_a  <= rf_raddr_a_nxt;
      rf_raddr_b  <= rf_raddr_b_nxt;
      rf_waddr    <= rf_waddr_nxt;
      rf_we       <= rf_we_nxt;
      alu_op      <= alu_op_nxt;
      alu_src_imm <= alu_src_imm_nxt;
      imm         <= imm_nxt;
      halted      <= halted_nxt;
      illegal     <= illegal_nxt;
      retired     <= retired_nxt;
    end
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed bench for ctrl_fsm with a small synchronous instruction memory and PC model.
module tb_ctrl_fsm;

  logic        clk;
  logic        reset;
  logic [15:0] instruction;
  logic        en_pc;
  logic [3:0]  rf_raddr_a;
  logic [3:0]  rf_raddr_b;
  logic [3:0]  rf_waddr;
  logic        rf_we;
  logic [3:0]  alu_op;
  logic        alu_src_imm;
  logic [7:0]  imm;
  logic        halted;
  logic        illegal;
  logic [15:0] retired;

  logic [15:0] mem [0:15];
  logic [3:0]  pc;

  int n_checks = 0;
  int n_pass   = 0;

  ctrl_fsm #(.HALT_OP(4'hF), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .en_pc       (en_pc),
    .rf_raddr_a  (rf_raddr_a),
    .rf_raddr_b  (rf_raddr_b),
    .rf_waddr    (rf_waddr),
    .rf_we       (rf_we),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .imm         (imm),
    .halted      (halted),
    .illegal     (illegal),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: output valid one cycle after the PC changes.
  always @(posedge clk) begin
    if (!reset) pc <= 4'd0;
    else if (en_pc) pc <= pc + 4'd1;
    instruction <= mem[pc];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".en_pc"}, 32'(en_pc), 32'd0);
    check({tag, ".rf_we"}, 32'(rf_we), 32'd0);
    check({tag, ".alu_op"}, 32'(alu_op), 32'd0);
    check({tag, ".src_imm"}, 32'(alu_src_imm), 32'd0);
    check({tag, ".imm"}, 32'(imm), 32'd0);
    check({tag, ".addrs"}, {20'd0, rf_raddr_a, rf_raddr_b, rf_waddr}, 32'd0);
    check({tag, ".halted"}, 32'(halted), 32'd0);
    check({tag, ".illegal"}, 32'(illegal), 32'd0);
    check({tag, ".retired"}, 32'(retired), 32'd0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
  endtask

  // Called at a negedge; returns at the release negedge, which is cycle 1.
  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    clear_mem();
    @(negedge clk);

    // NOP stream: en_pc on cycles 4, 8, 12; never rf_we.
    do_reset();
    check_idle("rst");
    for (int c = 1; c <= 12; c++) begin
      check($sformatf("nop.en_pc.c%0d", c), 32'(en_pc), (c % 4 == 0) ? 32'd1 : 32'd0);
      check($sformatf("nop.rf_we.c%0d", c), 32'(rf_we), 32'd0);
      next_cycle();
    end
    check("nop.retired", 32'(retired), 32'd3);

    // LDI r10, 0x5C.
    clear_mem();
    mem[0] = 16'h7A5C;
    do_reset();
    repeat (2) next_cycle();
    check("ldi.ex.alu_op", 32'(alu_op), 32'd7);
    check("ldi.ex.src_imm", 32'(alu_src_imm), 32'd1);
    check("ldi.ex.imm", 32'(imm), 32'h5C);
    check("ldi.ex.waddr", 32'(rf_waddr), 32'd10);
    check("ldi.ex.rf_we", 32'(rf_we), 32'd0);
    check("ldi.ex.en_pc", 32'(en_pc), 32'd0);
    next_cycle();
    check("ldi.wb.alu_op", 32'(alu_op), 32'd7);
    check("ldi.wb.src_imm", 32'(alu_src_imm), 32'd1);
    check("ldi.wb.imm", 32'(imm), 32'h5C);
    check("ldi.wb.rf_we", 32'(rf_we), 32'd1);
    check("ldi.wb.en_pc", 32'(en_pc), 32'd1);
    next_cycle();
    check("ldi.f.rf_we", 32'(rf_we), 32'd0);
    check("ldi.f.alu_op", 32'(alu_op), 32'd0);
    check("ldi.f.retired", 32'(retired), 32'd1);

    // ADD r3, r1, r2.
    clear_mem();
    mem[0] = 16'h1312;
    do_reset();
    repeat (2) next_cycle();
    check("add.ra", 32'(rf_raddr_a), 32'd1);
    check("add.rb", 32'(rf_raddr_b), 32'd2);
    check("add.wa", 32'(rf_waddr), 32'd3);
    check("add.alu_op", 32'(alu_op), 32'd1);
    check("add.src_imm", 32'(alu_src_imm), 32'd0);
    check("add.ex.rf_we", 32'(rf_we), 32'd0);
    next_cycle();
    check("add.wb.rf_we", 32'(rf_we), 32'd1);
    check("add.wb.retired", 32'(retired), 32'd0);
    next_cycle();
    check("add.f.rf_we", 32'(rf_we), 32'd0);
    check("add.f.retired", 32'(retired), 32'd1);

    // Undefined opcode, then a legal ADD: illegal is sticky, PC still advances.
    clear_mem();
    mem[0] = 16'hB000;
    mem[1] = 16'h1312;
    do_reset();
    repeat (3) next_cycle();
    check("undef.wb.rf_we", 32'(rf_we), 32'd0);
    check("undef.wb.alu_op", 32'(alu_op), 32'd0);
    check("undef.wb.en_pc", 32'(en_pc), 32'd1);
    check("undef.wb.illegal", 32'(illegal), 32'd0);
    next_cycle();
    check("undef.illegal", 32'(illegal), 32'd1);
    check("undef.retired", 32'(retired), 32'd1);
    repeat (3) next_cycle();
    check("undef.add.rf_we", 32'(rf_we), 32'd1);
    check("undef.add.alu_op", 32'(alu_op), 32'd1);
    next_cycle();
    check("undef.sticky", 32'(illegal), 32'd1);
    check("undef.retired2", 32'(retired), 32'd2);
    check("undef.pc", 32'(pc), 32'd2);

    // HALT after two NOPs.
    clear_mem();
    mem[2] = 16'hF000;
    do_reset();
    repeat (11) next_cycle();
    check("halt.wb.en_pc", 32'(en_pc), 32'd0);
    check("halt.wb.rf_we", 32'(rf_we), 32'd0);
    check("halt.wb.halted", 32'(halted), 32'd0);
    next_cycle();
    check("halt.halted", 32'(halted), 32'd1);
    mem[2] = 16'h1312;
    for (int c = 0; c < 24; c++) begin
      check($sformatf("halt.en_pc.%0d", c), 32'(en_pc), 32'd0);
      check($sformatf("halt.hold.%0d", c), {28'd0, halted, rf_we, alu_op == 4'd0, illegal}, 32'b1010);
      next_cycle();
    end
    check("halt.retired", 32'(retired), 32'd2);
    check("halt.pc", 32'(pc), 32'd2);
    do_reset();
    check_idle("halt.rst");

    // Reset during the EXEC of an ADD, after one NOP retired.
    clear_mem();
    mem[1] = 16'h1312;
    do_reset();
    repeat (6) next_cycle();
    check("rex.alu_op", 32'(alu_op), 32'd1);
    check("rex.retired", 32'(retired), 32'd1);
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    check_idle("rex.rst");
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("rex.en_pc.c%0d", c), 32'(en_pc), (c == 4) ? 32'd1 : 32'd0);
      next_cycle();
    end

    // Reset landing on the WB edge: no retire, no write.
    clear_mem();
    mem[0] = 16'h1312;
    do_reset();
    repeat (3) next_cycle();
    check("rwb.rf_we", 32'(rf_we), 32'd1);
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    check("rwb.rf_we.after", 32'(rf_we), 32'd0);
    check("rwb.retired", 32'(retired), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
